// File: rtl/dmem_bytelane.sv
// Byte-addressable data memory for the MEM stage: sized loads/stores with extension,
// error reporting, a valid/ready request port and a post-reset initialisation sweep.
module dmem_bytelane #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 32,
    parameter int READ_LAT  = 1,
    parameter int INIT_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rsp_err,
    output logic              init_done
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_init_idx;
    logic               w_sweep_we;
    logic               w_ready;
    logic               w_done;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic [OFF_W-1:0]   w_off;
    logic [IDX_W-1:0]   w_idx;
    logic               w_out_of_range;
    logic               w_misaligned;
    logic               w_illegal_size;
    logic               w_err;
    logic               w_accept;
    logic               w_store;
    logic [NB-1:0]      w_lanes;
    logic [NB-1:0]      w_be;
    logic [DATA_W-1:0]  w_wdata_sh;
    logic [DATA_W-1:0]  w_init_word;
    logic [DATA_W-1:0]  w_word;
    logic [DATA_W-1:0]  w_word_sh;
    logic [DATA_W-1:0]  w_rsp_data;

    logic               r_vld_p1;
    logic [DATA_W-1:0]  r_data_p1;
    logic               r_err_p1;

    // Keeps the selected low bytes and fills the rest with zeros or the sign bit.
    function automatic logic [DATA_W-1:0] f_extend(input logic [DATA_W-1:0] v,
                                                   input logic [1:0] size,
                                                   input logic uns);
        logic [DATA_W-1:0] m;
        logic              s;
        case (size)
            2'd0:    begin m = DATA_W'(8'hFF);         s = v[7];  end
            2'd1:    begin m = DATA_W'(16'hFFFF);      s = v[15]; end
            2'd2:    begin m = DATA_W'(32'hFFFF_FFFF); s = v[31]; end
            default: begin m = '1;                     s = 1'b0;  end
        endcase
        return (v & m) | ((!uns && s) ? ~m : '0);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_INIT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_we  = 1'b0;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_sweep_we = 1'b1;
                if (r_init_idx == IDX_W'(DEPTH - 1)) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                w_ready = 1'b1;
                w_done  = 1'b1;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // The counter wraps back to 0 on the last sweep write since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_init_idx <= '0;
        else if (w_sweep_we) r_init_idx <= r_init_idx + IDX_W'(1);
    end

    assign req_ready = w_ready;
    assign init_done = w_done;

    assign w_off          = addr[OFF_W-1:0];
    assign w_idx          = addr[OFF_W +: IDX_W];
    assign w_out_of_range = (addr >> (OFF_W + IDX_W)) != '0;
    assign w_illegal_size = (req_size == 2'd3) && (DATA_W == 32);
    assign w_err          = w_out_of_range | w_misaligned | w_illegal_size;
    assign w_accept       = req_valid & w_ready;
    assign w_store        = w_accept & req_we & ~w_err;

    always_comb begin
        w_misaligned = 1'b0;
        w_lanes      = '1;
        case (req_size)
            2'd0:    begin w_misaligned = 1'b0;        w_lanes = NB'(1);  end
            2'd1:    begin w_misaligned = w_off[0];    w_lanes = NB'(3);  end
            2'd2:    begin w_misaligned = |w_off[1:0]; w_lanes = NB'(15); end
            default: begin w_misaligned = |w_off;      w_lanes = '1;      end
        endcase
    end

    assign w_be        = w_lanes << w_off;
    assign w_wdata_sh  = wdata << {w_off, 3'b000};
    assign w_init_word = (INIT_MODE == 1) ? DATA_W'(r_init_idx) : '0;

    always_ff @(posedge clk) begin
        if (w_sweep_we) begin
            r_mem[r_init_idx] <= w_init_word;
        end else if (w_store) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
        end
    end

    assign w_word     = r_mem[w_idx];
    assign w_word_sh  = w_word >> {w_off, 3'b000};
    assign w_rsp_data = (req_we || w_err) ? '0 : f_extend(w_word_sh, req_size, req_unsigned);

    // Stage p1: response captured on the acceptance edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_err_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept;
            if (w_accept) begin
                r_data_p1 <= w_rsp_data;
                r_err_p1  <= w_err;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              r_vld_p2;
            logic [DATA_W-1:0] r_data_p2;
            logic              r_err_p2;

            // Stage p2: plain delay register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld_p2  <= 1'b0;
                    r_data_p2 <= '0;
                    r_err_p2  <= 1'b0;
                end else begin
                    r_vld_p2 <= r_vld_p1;
                    if (r_vld_p1) begin
                        r_data_p2 <= r_data_p1;
                        r_err_p2  <= r_err_p1;
                    end
                end
            end

            assign rsp_valid = r_vld_p2;
            assign rdata     = r_data_p2;
            assign rsp_err   = r_err_p2;
        end else begin : g_lat1
            assign rsp_valid = r_vld_p1;
            assign rdata     = r_data_p1;
            assign rsp_err   = r_err_p1;
        end
    endgenerate
endmodule
